// File: rtl/count_down_monitor_if.sv
// Signal bundle between an upstream 4-bit down counter and its step monitor.
// The master drives the sampled count and clear; the slave returns the statistics.
interface count_down_monitor_if #(
  parameter int CYC_W = 8,
  parameter int ERR_W = 4
);
  logic [3:0]       count;
  logic             clr;
  logic             wrap;
  logic [CYC_W-1:0] cycles;
  logic             fault;
  logic [ERR_W-1:0] errs;
  logic             zero;

  modport master (output count, clr, input wrap, cycles, fault, errs, zero);
  modport slave  (input count, clr, output wrap, cycles, fault, errs, zero);
endinterface

// File: rtl/count_down_monitor.sv
// Watches a free-running 4-bit down counter: counts 0->15 wraps, flags and
// counts illegal steps. All outputs are registered.
module count_down_monitor #(
  parameter int CYC_W = 8,
  parameter int ERR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  count_down_monitor_if.slave mon
);

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  localparam logic [CYC_W-1:0] CYC_MAX = '1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           state;
  logic [3:0]       prev;
  logic             wrap_q;
  logic [CYC_W-1:0] cycles_q;
  logic             fault_q;
  logic [ERR_W-1:0] errs_q;
  logic             zero_q;
  logic [3:0]       expected;

  // 4-bit subtraction so that prev=0 expects 15.
  assign expected = prev - 4'd1;

  // NOTE: every register here uses non-blocking assignment so all state
  // updates see the pre-edge values of prev, state and the counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      prev     <= 4'd0;
      wrap_q   <= 1'b0;
      cycles_q <= '0;
      fault_q  <= 1'b0;
      errs_q   <= '0;
      zero_q   <= 1'b0;
    end else begin
      zero_q <= (mon.count == 4'd0);
      wrap_q <= 1'b0;
      prev   <= mon.count;
      if (mon.clr) begin
        cycles_q <= '0;
        errs_q   <= '0;
        fault_q  <= 1'b0;
        state    <= TRACK;
      end else begin
        case (state)
          IDLE: state <= TRACK;
          TRACK, FAULT: begin
            if (mon.count == expected) begin
              if (prev == 4'd0) begin
                wrap_q <= 1'b1;
                if (cycles_q != CYC_MAX) cycles_q <= cycles_q + 1'b1;
              end
            end else begin
              if (errs_q != ERR_MAX) errs_q <= errs_q + 1'b1;
              fault_q <= 1'b1;
              state   <= FAULT;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign mon.wrap   = wrap_q;
  assign mon.cycles = cycles_q;
  assign mon.fault  = fault_q;
  assign mon.errs   = errs_q;
  assign mon.zero   = zero_q;

endmodule
